cpu_bus_decoder: RTL and testbench

CPU_BUS_DECODER -- requirements
Module: cpu_bus_decoder

---
 rtl/cpu_bus_decoder_if.sv | 42 ++++
 rtl/cpu_bus_decoder.sv | 120 ++++++++++++
 tb/tb_cpu_bus_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_decoder_if.sv
// CPU-side and slave-side bus bundle for cpu_bus_decoder.
// The decoder takes the slave modport; the CPU/slave environment takes master.
interface cpu_bus_decoder_if;
   logic        cpud_request;
   logic [31:0] cpud_addr;
   logic        cpud_write;
   logic [3:0]  cpud_byte_enable;
   logic [31:0] cpud_wdata;
   logic [31:0] cpud_rdata;
   logic        cpud_ack;

   logic        mem_request;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   logic        hwr_request;
   logic [15:0] hwr_addr;
   logic [31:0] hwr_rdata;
   logic        hwr_ack;

   logic        slv_write;
   logic [3:0]  slv_byte_enable;
   logic [31:0] slv_wdata;

   logic        bus_error;
   logic        protocol_error;

   modport slave (
      input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
      input  mem_rdata, mem_ack, hwr_rdata, hwr_ack,
      output cpud_rdata, cpud_ack, mem_request, mem_addr, hwr_request, hwr_addr,
      output slv_write, slv_byte_enable, slv_wdata, bus_error, protocol_error
   );

   modport master (
      output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata,
      output mem_rdata, mem_ack, hwr_rdata, hwr_ack,
      input  cpud_rdata, cpud_ack, mem_request, mem_addr, hwr_request, hwr_addr,
      input  slv_write, slv_byte_enable, slv_wdata, bus_error, protocol_error
   );
endinterface

// File: rtl/cpu_bus_decoder.sv
// CPU bus decoder: routes one outstanding CPU access to main memory or the
// hardware register block. Optional ack watchdog enabled by BUS_TIMEOUT_EN.
module cpu_bus_decoder #(
   parameter int          TIMEOUT_CYCLES = 256,
   parameter logic [31:0] MEM_TOP        = 32'h3FFFFFFF
) (
   input  logic              clock,
   input  logic              reset,
   cpu_bus_decoder_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MEM_WAIT, HWR_WAIT, ERR_ACK} state_t;

   state_t state;
   logic   hit_mem;
   logic   hit_hwr;
   logic   accept;
   logic   expired;

   assign hit_mem = (bus.cpud_addr <= MEM_TOP);
   assign hit_hwr = !hit_mem && (bus.cpud_addr[31:16] == 16'hE000);
   // The cycle carrying cpud_ack still counts as busy, so requests there are dropped.
   assign accept  = bus.cpud_request && (state == IDLE) && !bus.cpud_ack;

`ifdef BUS_TIMEOUT_EN
   localparam int             CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;

   assign expired = (wait_cnt == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (accept)
         wait_cnt <= '0;
      else if (state == MEM_WAIT || state == HWR_WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   // No watchdog: a slave may hold the bus forever.
   assign expired = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         bus.cpud_ack        <= 1'b0;
         bus.cpud_rdata      <= '0;
         bus.mem_request     <= 1'b0;
         bus.mem_addr        <= '0;
         bus.hwr_request     <= 1'b0;
         bus.hwr_addr        <= '0;
         bus.slv_write       <= 1'b0;
         bus.slv_byte_enable <= '0;
         bus.slv_wdata       <= '0;
         bus.bus_error       <= 1'b0;
         bus.protocol_error  <= 1'b0;
      end else begin
         bus.cpud_ack    <= 1'b0;
         bus.cpud_rdata  <= '0;
         bus.bus_error   <= 1'b0;
         bus.mem_request <= 1'b0;
         bus.hwr_request <= 1'b0;

         if (bus.cpud_request && !accept)
            bus.protocol_error <= 1'b1;

         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit_mem || hit_hwr) begin
                     bus.slv_write       <= bus.cpud_write;
                     bus.slv_byte_enable <= bus.cpud_byte_enable;
                     bus.slv_wdata       <= bus.cpud_wdata;
                  end
                  if (hit_mem) begin
                     state           <= MEM_WAIT;
                     bus.mem_request <= 1'b1;
                     bus.mem_addr    <= bus.cpud_addr;
                  end else if (hit_hwr) begin
                     state           <= HWR_WAIT;
                     bus.hwr_request <= 1'b1;
                     bus.hwr_addr    <= bus.cpud_addr[15:0];
                  end else begin
                     state <= ERR_ACK;
                  end
               end
            end
            MEM_WAIT: begin
               if (bus.mem_ack) begin
                  state          <= IDLE;
                  bus.cpud_ack   <= 1'b1;
                  bus.cpud_rdata <= bus.mem_rdata;
               end else if (expired) begin
                  state <= ERR_ACK;
               end
            end
            HWR_WAIT: begin
               if (bus.hwr_ack) begin
                  state          <= IDLE;
                  bus.cpud_ack   <= 1'b1;
                  bus.cpud_rdata <= bus.hwr_rdata;
               end else if (expired) begin
                  state <= ERR_ACK;
               end
            end
            ERR_ACK: begin
               state          <= IDLE;
               bus.cpud_ack   <= 1'b1;
               bus.cpud_rdata <= 32'hDEADBEEF;
               bus.bus_error  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Bench for cpu_bus_decoder: a cycle-indexed transaction model schedules the
// expected outputs, a negedge process compares every cycle, plus literal checks.
module tb_cpu_bus_decoder;
   localparam int          TO      = 16;
   localparam logic [31:0] MEM_TOP = 32'h3FFFFFFF;
   localparam int          MAXC    = 1024;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   cpu_bus_decoder_if bus();

   cpu_bus_decoder #(.TIMEOUT_CYCLES(TO), .MEM_TOP(MEM_TOP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // expected outputs, indexed by cycle number
   bit        exp_ack  [MAXC];
   bit [31:0] exp_rd   [MAXC];
   bit        exp_berr [MAXC];
   bit        exp_mreq [MAXC];
   bit        exp_hreq [MAXC];
   bit        exp_perr [MAXC];
   bit [31:0] exp_a    [MAXC];
   bit        exp_w    [MAXC];
   bit [3:0]  exp_be   [MAXC];
   bit [31:0] exp_wd   [MAXC];

   int pend_kind = 0;    // 0 none, 1 memory, 2 hw registers
   int pend_strobe = 0;
   int pend_end = 0;     // last cycle a slave ack is still honoured
   int busy_until = -1;  // requests at or before this cycle are dropped
   int tout_ack = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic void mark_ack(int c, bit [31:0] d, bit be);
      if (c < MAXC) begin
         exp_ack[c] = 1'b1; exp_rd[c] = d; exp_berr[c] = be;
      end
   endfunction

   function automatic void model_req(int n, bit [31:0] a, bit w, bit [3:0] be, bit [31:0] wd);
      int s;
      if (n <= busy_until) begin
         for (int c = n + 1; c < MAXC; c++) exp_perr[c] = 1'b1;
         return;
      end
      if (a <= MEM_TOP || a[31:16] == 16'hE000) begin
         s = n + 1;
         pend_kind = (a <= MEM_TOP) ? 1 : 2;
         if (pend_kind == 1) begin
            exp_mreq[s] = 1'b1; exp_a[s] = a;
         end else begin
            exp_hreq[s] = 1'b1; exp_a[s] = {16'h0, a[15:0]};
         end
         exp_w[s] = w; exp_be[s] = be; exp_wd[s] = wd;
         pend_strobe = s;
`ifdef BUS_TIMEOUT_EN
         pend_end   = s + TO - 1;
         tout_ack   = s + TO + 1;
         busy_until = tout_ack;
         mark_ack(tout_ack, 32'hDEADBEEF, 1'b1);
`else
         pend_end   = MAXC;
         busy_until = MAXC;
`endif
      end else begin
         mark_ack(n + 2, 32'hDEADBEEF, 1'b1);
         busy_until = n + 2;
      end
   endfunction

   function automatic void model_slave_ack(int k, int kind, bit [31:0] d);
      if (pend_kind == kind && k >= pend_strobe && k <= pend_end) begin
         if (tout_ack >= 0 && tout_ack < MAXC) begin
            exp_ack[tout_ack] = 1'b0; exp_rd[tout_ack] = '0; exp_berr[tout_ack] = 1'b0;
         end
         tout_ack = -1;
         mark_ack(k + 1, d, 1'b0);
         busy_until = k + 1;
         pend_kind = 0;
      end
   endfunction

   function automatic void model_reset(int c);
      pend_kind = 0; busy_until = -1; tout_ack = -1;
      for (int i = c; i < MAXC; i++) begin
         exp_ack[i] = 0; exp_rd[i] = 0; exp_berr[i] = 0; exp_mreq[i] = 0;
         exp_hreq[i] = 0; exp_perr[i] = 0;
      end
   endfunction

   always @(negedge clock) begin
      if (cyc < MAXC) begin
         chk("cpud_ack", bus.cpud_ack, exp_ack[cyc]);
         chk("cpud_rdata", bus.cpud_rdata, exp_rd[cyc]);
         chk("bus_error", bus.bus_error, exp_berr[cyc]);
         chk("mem_request", bus.mem_request, exp_mreq[cyc]);
         chk("hwr_request", bus.hwr_request, exp_hreq[cyc]);
         chk("protocol_error", bus.protocol_error, exp_perr[cyc]);
         if (exp_mreq[cyc]) chk("mem_addr", bus.mem_addr, exp_a[cyc]);
         if (exp_hreq[cyc]) chk("hwr_addr", bus.hwr_addr, exp_a[cyc]);
         if (exp_mreq[cyc] || exp_hreq[cyc]) begin
            chk("slv_write", bus.slv_write, exp_w[cyc]);
            chk("slv_byte_enable", bus.slv_byte_enable, exp_be[cyc]);
            chk("slv_wdata", bus.slv_wdata, exp_wd[cyc]);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_req(input bit [31:0] a, input bit w, input bit [3:0] be, input bit [31:0] wd);
      bus.cpud_request = 1'b1; bus.cpud_addr = a; bus.cpud_write = w;
      bus.cpud_byte_enable = be; bus.cpud_wdata = wd;
      model_req(cyc, a, w, be, wd);
      step();
      bus.cpud_request = 1'b0; bus.cpud_addr = '0; bus.cpud_write = 1'b0;
      bus.cpud_byte_enable = '0; bus.cpud_wdata = '0;
   endtask

   task automatic slv_ack(input int kind, input bit [31:0] d);
      if (kind == 1) begin
         bus.mem_ack = 1'b1; bus.mem_rdata = d;
      end else begin
         bus.hwr_ack = 1'b1; bus.hwr_rdata = d;
      end
      model_slave_ack(cyc, kind, d);
      step();
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.hwr_ack = 1'b0; bus.hwr_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.cpud_request = 1'b0; bus.cpud_addr = '0; bus.cpud_write = 1'b0;
      bus.cpud_byte_enable = '0; bus.cpud_wdata = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.hwr_ack = 1'b0; bus.hwr_rdata = '0;

      idle(3);
      chk("rst_ack", bus.cpud_ack, 0);
      chk("rst_rdata", bus.cpud_rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_hwr_addr", bus.hwr_addr, 0);
      chk("rst_slv_wdata", bus.slv_wdata, 0);
      chk("rst_slv_be", bus.slv_byte_enable, 0);
      chk("rst_perr", bus.protocol_error, 0);
      reset = 1'b0;

      // hw register read, acked on the strobe cycle
      do_req(32'hE0000008, 1'b0, 4'h0, 32'h0);
      chk("t1_strobe", bus.hwr_request, 1);
      chk("t1_hwr_addr", bus.hwr_addr, 32'h0008);
      slv_ack(2, 32'h3FF);
      chk("t1_ack", bus.cpud_ack, 1);
      chk("t1_rdata", bus.cpud_rdata, 32'h3FF);
      idle(2);

      // memory write, slow ack
      do_req(32'h00001000, 1'b1, 4'hF, 32'h12345678);
      chk("t2_strobe", bus.mem_request, 1);
      chk("t2_wdata", bus.slv_wdata, 32'h12345678);
      idle(4);
      slv_ack(1, 32'h0);
      chk("t2_ack", bus.cpud_ack, 1);
      chk("t2_rdata", bus.cpud_rdata, 0);
      idle(2);

      // unmapped read
      do_req(32'h80000000, 1'b0, 4'h0, 32'h0);
      idle(1);
      chk("t3_ack", bus.cpud_ack, 1);
      chk("t3_berr", bus.bus_error, 1);
      chk("t3_rdata", bus.cpud_rdata, 32'hDEADBEEF);
      idle(2);

      // overlapping request, cross ack ignored, request on the ack cycle
      do_req(32'h00000040, 1'b0, 4'h0, 32'h0);
      idle(1);
      do_req(32'hE0000000, 1'b0, 4'h0, 32'h0);
      chk("t4_perr", bus.protocol_error, 1);
      slv_ack(2, 32'h11111111);
      slv_ack(1, 32'hA5A5A5A5);
      chk("t4_ack", bus.cpud_ack, 1);
      chk("t4_rdata", bus.cpud_rdata, 32'hA5A5A5A5);
      do_req(32'h00000100, 1'b0, 4'h0, 32'h0);
      chk("t4_dropped", bus.mem_request, 0);
      idle(2);

      // stale ack in idle
      slv_ack(1, 32'hFFFF0000);
      idle(1);

      // partial-lane hw register write
      do_req(32'hE0001234, 1'b1, 4'b0101, 32'hCAFEF00D);
      idle(2);
      slv_ack(2, 32'h0);
      idle(2);

`ifdef BUS_TIMEOUT_EN
      // never-acked read times out, late ack is discarded
      do_req(32'hE0000010, 1'b0, 4'h0, 32'h0);
      idle(17);
      chk("t7_ack", bus.cpud_ack, 1);
      chk("t7_berr", bus.bus_error, 1);
      chk("t7_rdata", bus.cpud_rdata, 32'hDEADBEEF);
      slv_ack(2, 32'h55);
      idle(2);
      // ack on the expiry cycle wins
      do_req(32'hE0000020, 1'b0, 4'h0, 32'h0);
      idle(15);
      slv_ack(2, 32'h600D600D);
      chk("t7b_ack", bus.cpud_ack, 1);
      chk("t7b_rdata", bus.cpud_rdata, 32'h600D600D);
      idle(2);
`else
      // long wait is never cut short
      do_req(32'hE0000010, 1'b0, 4'h0, 32'h0);
      idle(39);
      slv_ack(2, 32'h77);
      chk("t7_ack", bus.cpud_ack, 1);
      chk("t7_rdata", bus.cpud_rdata, 32'h77);
      chk("t7_berr", bus.bus_error, 0);
      idle(2);
`endif

      // reset while waiting on the hw registers
      do_req(32'hE0000004, 1'b0, 4'h0, 32'h0);
      idle(1);
      reset = 1'b1;
      model_reset(cyc);
      #1;
      chk("t8_perr", bus.protocol_error, 0);
      chk("t8_hwr_addr", bus.hwr_addr, 0);
      step();
      reset = 1'b0;
      slv_ack(2, 32'h999);
      idle(2);
      do_req(32'h00002000, 1'b0, 4'h0, 32'h0);
      slv_ack(1, 32'h2468ACE0);
      chk("t8_ack", bus.cpud_ack, 1);
      chk("t8_rdata", bus.cpud_rdata, 32'h2468ACE0);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
